// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline sequencer.
//   NOP_INSTR   - ARM "MOV r0,r0", the filler for empty slots.
//   SEL_PC_BOOT - PC mux select forced while booting.
//   seq_state_t - sequencer FSM states.
package pipe_ctrl_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'hE1A00000;
  localparam logic [1:0]  SEL_PC_BOOT = 2'b01;

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} seq_state_t;
endpackage

// File: rtl/pipe_seq_ctrl_slot.sv
// pipe_slot: one pipeline slot (instruction word + valid bit).
//   clk, rst            - clock, async active-high reset
//   i_load              - capture i_instr/i_valid
//   i_bubble            - become a bubble (NOP, invalid); wins over i_load
//   i_instr, i_valid    - incoming slot contents
//   o_instr, o_valid    - registered slot contents
// Holds when neither i_load nor i_bubble is set.
module pipe_slot
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= INSTR_W'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= INSTR_W'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_valid = r_valid;
endmodule

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: pipeline sequencer. Boot FSM forcing PC load, a chain of
// instruction slots (slot 0 youngest) with stall/bubble and branch flush,
// and a saturating retire counter.
//   clk, rst                 - clock, async active-high reset
//   instr_in, instr_valid_in - fetched instruction
//   stall, stall_at          - hold slots 0..stall_at, bubble above
//   flush                    - branch taken in BRANCH_STAGE; beats stall
//   pc_sel_req, pc_load_req  - PC control from the memory-stage decoder
//   stage_instr, stage_valid - per-slot contents (registered)
//   sel_pc, load_pc          - PC mux select / enable (combinational)
//   in_ready                 - instr_in accepted this cycle (combinational)
//   boot_done                - sequencer in RUN (registered)
//   retired_count            - saturating count of retired instructions
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int INSTR_W      = 32,
  parameter int BRANCH_STAGE = 1,
  parameter int BOOT_CYCLES  = 1,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INSTR_W-1:0]            instr_in,
  input  logic                          instr_valid_in,
  input  logic                          stall,
  input  logic [$clog2(NUM_STAGES)-1:0] stall_at,
  input  logic                          flush,
  input  logic [1:0]                    pc_sel_req,
  input  logic                          pc_load_req,
  output logic [NUM_STAGES*INSTR_W-1:0] stage_instr,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic [1:0]                    sel_pc,
  output logic                          load_pc,
  output logic                          in_ready,
  output logic                          boot_done,
  output logic [CNT_W-1:0]              retired_count
);
  localparam int BC_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  seq_state_t                           r_state;
  logic [BC_W-1:0]                      r_boot_cnt;
  logic                                 r_boot_done;
  logic [CNT_W-1:0]                     r_retired;

  logic [NUM_STAGES-1:0][INSTR_W-1:0]   w_slot_instr;
  logic [NUM_STAGES-1:0]                w_slot_valid;
  logic [NUM_STAGES-1:0]                w_load;
  logic [NUM_STAGES-1:0]                w_bubble;
  logic                                 w_run;
  logic                                 w_stall_eff;
  logic                                 w_retire;

  assign w_run       = (r_state == RUN);
  // Flush overrides stall; nothing moves in BOOT.
  assign w_stall_eff = stall & ~flush;

  always_comb begin
    w_load   = '0;
    w_bubble = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (w_run) begin
        if (flush) begin
          if (i <= BRANCH_STAGE) w_bubble[i] = 1'b1;
          else                   w_load[i]   = 1'b1;
        end else if (stall) begin
          if (i == int'(stall_at) + 1)   w_bubble[i] = 1'b1;
          else if (i > int'(stall_at))   w_load[i]   = 1'b1;
        end else begin
          w_load[i] = 1'b1;
        end
      end
    end
  end

  // Last slot leaves unless it is itself held by the stall.
  assign w_retire = w_run & w_slot_valid[NUM_STAGES-1] &
                    ~(w_stall_eff & (int'(stall_at) == NUM_STAGES-1));

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
    logic [INSTR_W-1:0] w_d_instr;
    logic               w_d_valid;
    if (i == 0) begin : g_head
      assign w_d_instr = instr_in;
      assign w_d_valid = instr_valid_in;
    end else begin : g_body
      assign w_d_instr = w_slot_instr[i-1];
      assign w_d_valid = w_slot_valid[i-1];
    end
    pipe_slot #(.INSTR_W(INSTR_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load[i]),
      .i_bubble (w_bubble[i]),
      .i_instr  (w_d_instr),
      .i_valid  (w_d_valid),
      .o_instr  (w_slot_instr[i]),
      .o_valid  (w_slot_valid[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BOOT;
      r_boot_cnt  <= '0;
      r_boot_done <= 1'b0;
      r_retired   <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          if (r_boot_cnt == BC_W'(BOOT_CYCLES - 1)) begin
            r_state     <= RUN;
            r_boot_done <= 1'b1;
          end else begin
            r_boot_cnt <= r_boot_cnt + BC_W'(1);
          end
        end
        RUN: begin
          if (w_retire && (r_retired != '1))
            r_retired <= r_retired + CNT_W'(1);
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign sel_pc        = w_run ? pc_sel_req  : SEL_PC_BOOT;
  assign load_pc       = w_run ? pc_load_req : 1'b1;
  assign in_ready      = w_run & (~stall | flush);
  assign stage_instr   = w_slot_instr;
  assign stage_valid   = w_slot_valid;
  assign boot_done     = r_boot_done;
  assign retired_count = r_retired;
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BR = 1;
  localparam int BC = 3;
  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;

  typedef struct {
    logic [1:0] sel;
    logic       ld;
    logic       rdy;
  } comb_exp_t;

  typedef struct {
    logic [N*W-1:0] instr;
    logic [N-1:0]   valid;
    logic [CW-1:0]  ret;
    logic           done;
  } reg_exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [W-1:0]         instr_in = '0;
  logic                 instr_valid_in = 1'b0;
  logic                 stall = 1'b0;
  logic [1:0]           stall_at = '0;
  logic                 flush = 1'b0;
  logic [1:0]           pc_sel_req = '0;
  logic                 pc_load_req = 1'b0;
  logic [N*W-1:0]       stage_instr;
  logic [N-1:0]         stage_valid;
  logic [1:0]           sel_pc;
  logic                 load_pc;
  logic                 in_ready;
  logic                 boot_done;
  logic [CW-1:0]        retired_count;

  pipe_seq_ctrl #(.NUM_STAGES(N), .INSTR_W(W), .BRANCH_STAGE(BR),
                  .BOOT_CYCLES(BC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
    .stall(stall), .stall_at(stall_at), .flush(flush),
    .pc_sel_req(pc_sel_req), .pc_load_req(pc_load_req),
    .stage_instr(stage_instr), .stage_valid(stage_valid),
    .sel_pc(sel_pc), .load_pc(load_pc), .in_ready(in_ready),
    .boot_done(boot_done), .retired_count(retired_count));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: slots as arrays, boot as cycles remaining.
  logic [W-1:0] m_instr[N];
  bit           m_valid[N];
  int           m_boot_left;
  int           m_ret;

  comb_exp_t q_comb[$];
  reg_exp_t  q_reg[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_instr[i] = NOP;
      m_valid[i] = 1'b0;
    end
    m_boot_left = BC;
    m_ret       = 0;
    q_comb.delete();
    q_reg.delete();
  endtask

  task automatic check_reset_vals(string tag);
    logic [N*W-1:0] nops;
    nops = {N{NOP}};
    chk({tag, "_instr"}, stage_instr, nops);
    chk({tag, "_valid"}, stage_valid, '0);
    chk({tag, "_ret"}, retired_count, '0);
    chk({tag, "_done"}, boot_done, 1'b0);
    chk({tag, "_rdy"}, in_ready, 1'b0);
    chk({tag, "_sel"}, sel_pc, 2'b01);
    chk({tag, "_ld"}, load_pc, 1'b1);
  endtask

  // Drive one cycle of inputs, predict, push expectations, advance to next negedge.
  task automatic cycle(logic v, logic [W-1:0] ins, logic st, logic [1:0] sa,
                       logic fl, logic [1:0] ps, logic pl);
    comb_exp_t    ce;
    reg_exp_t     re;
    logic [W-1:0] ni[N];
    bit           nv[N];
    bit           leaves;
    bit           run;
    instr_in = ins; instr_valid_in = v; stall = st; stall_at = sa;
    flush = fl; pc_sel_req = ps; pc_load_req = pl;
    run    = (m_boot_left == 0);
    ce.sel = run ? ps : 2'b01;
    ce.ld  = run ? pl : 1'b1;
    ce.rdy = run && (!st || fl);
    q_comb.push_back(ce);
    if (!run) begin
      m_boot_left--;
    end else begin
      leaves = 1'b1;
      for (int i = 0; i < N; i++) begin
        ni[i] = m_instr[i];
        nv[i] = m_valid[i];
      end
      if (fl) begin
        for (int i = 0; i < N; i++) begin
          if (i <= BR) begin ni[i] = NOP; nv[i] = 1'b0; end
          else begin ni[i] = m_instr[i-1]; nv[i] = m_valid[i-1]; end
        end
      end else if (st) begin
        leaves = (int'(sa) != N-1);
        for (int i = int'(sa) + 1; i < N; i++) begin
          if (i == int'(sa) + 1) begin ni[i] = NOP; nv[i] = 1'b0; end
          else begin ni[i] = m_instr[i-1]; nv[i] = m_valid[i-1]; end
        end
      end else begin
        ni[0] = ins; nv[0] = v;
        for (int i = 1; i < N; i++) begin ni[i] = m_instr[i-1]; nv[i] = m_valid[i-1]; end
      end
      if (leaves && m_valid[N-1] && m_ret < (1 << CW) - 1) m_ret++;
      for (int i = 0; i < N; i++) begin m_instr[i] = ni[i]; m_valid[i] = nv[i]; end
    end
    for (int i = 0; i < N; i++) begin
      re.instr[i*W +: W] = m_instr[i];
      re.valid[i]        = m_valid[i];
    end
    re.ret  = CW'(m_ret);
    re.done = (m_boot_left == 0);
    q_reg.push_back(re);
    @(negedge clk);
  endtask

  task automatic rnd_cycle(int p_stall, int p_flush);
    cycle(1'($urandom), $urandom, ($urandom_range(99) < p_stall),
          2'($urandom), ($urandom_range(99) < p_flush), 2'($urandom), 1'($urandom));
  endtask

  task automatic plain(logic [W-1:0] ins);
    cycle(1'b1, ins, 1'b0, 2'd0, 1'b0, 2'($urandom), 1'($urandom));
  endtask

  // Monitors: combinational outputs mid low phase, registered outputs after the edge.
  initial forever begin
    comb_exp_t e;
    @(negedge clk); #2;
    if (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      chk("sel_pc", sel_pc, e.sel);
      chk("load_pc", load_pc, e.ld);
      chk("in_ready", in_ready, e.rdy);
    end
  end

  initial forever begin
    reg_exp_t e;
    @(posedge clk); #1;
    if (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      chk("stage_instr", stage_instr, e.instr);
      chk("stage_valid", stage_valid, e.valid);
      chk("retired_count", retired_count, e.ret);
      chk("boot_done", boot_done, e.done);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*W-1:0] exp_stream;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Boot: inputs are random and must be ignored.
    for (int i = 0; i < BC; i++) rnd_cycle(50, 50);

    plain(32'h11); plain(32'h22); plain(32'h33); plain(32'h44);
    exp_stream = {32'h11, 32'h22, 32'h33, 32'h44};
    chk("stream_slots", stage_instr, exp_stream);
    chk("stream_valid", stage_valid, 4'hF);

    // Stall at slot 0 for two cycles.
    cycle(1'b1, 32'h55, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0);
    cycle(1'b1, 32'h66, 1'b1, 2'd0, 1'b0, 2'd3, 1'b1);

    // Refill, then flush with all four slots valid.
    plain(32'hA1); plain(32'hA2); plain(32'hA3); plain(32'hA4);
    cycle(1'b1, 32'hBAD, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    chk("flush_slot2", stage_instr[2*W +: W], 32'hA3);

    // Flush together with stall: flush wins.
    plain(32'hC1); plain(32'hC2);
    cycle(1'b1, 32'hBAD2, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1);

    for (int i = 0; i < 300; i++) rnd_cycle(30, 15);

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b1;
    #1 check_reset_vals("midrst");
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;

    // Saturation: boot, then 40 cycles of valid instructions.
    for (int i = 0; i < BC; i++) rnd_cycle(0, 0);
    for (int i = 0; i < 40; i++) plain($urandom);
    chk("saturated", retired_count, 4'hF);

    repeat (2) @(negedge clk);
    chk("q_drained", 128'(q_comb.size() + q_reg.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
